// File: rtl/alu_seq.sv
// alu_seq: runs an NBYTES-wide operation through the shared 8-bit ALU one
// byte per cycle, least-significant byte first, chaining carry between bytes,
// and presents the assembled result on a valid/ready response port.
module alu_seq #(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    input  logic [3:0]            req_sel,
    input  logic                  req_c_in,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_c_in,
    output logic [3:0]            alu_sel,
    input  logic [7:0]            alu_out,
    input  logic                  alu_c_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_result,
    output logic                  rsp_c_out,
    output logic                  rsp_zero
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IW-1:0]         idx;
    logic [8*NBYTES-1:0]   a_q;
    logic [8*NBYTES-1:0]   b_q;
    logic [8*NBYTES-1:0]   result;
    logic [3:0]            sel_q;
    logic                  cy;

    // Current byte is selected by shifting rather than a variable part-select,
    // so the index width never has to match the operand width exactly.
    logic [IW+2:0]         bit_off;
    logic [8*NBYTES-1:0]   a_sh;
    logic [8*NBYTES-1:0]   b_sh;

    assign bit_off = {idx, 3'b000};
    assign a_sh    = a_q >> bit_off;
    assign b_sh    = b_q >> bit_off;

    assign rsp_result = result;
    assign rsp_c_out  = cy;
    assign rsp_zero   = (result == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, handshake outputs and ALU drive (zero outside EXEC).
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_c_in  = 1'b0;
        alu_sel   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                alu_a    = a_sh[7:0];
                alu_b    = b_sh[7:0];
                alu_c_in = cy;
                alu_sel  = sel_q;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch on acceptance, then per-byte result capture and carry chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sel_q  <= '0;
            cy     <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_q   <= req_a;
                        b_q   <= req_b;
                        sel_q <= req_sel;
                        cy    <= req_c_in;
                        idx   <= '0;
                    end
                end
                EXEC: begin
                    for (int unsigned k = 0; k < NBYTES; k++) begin
                        if (idx == IW'(k)) begin
                            result[8*k +: 8] <= alu_out;
                        end
                    end
                    cy <= alu_c_out;
                    if (idx != LAST_IDX) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 2-byte and a 1-byte instance, each wired to a
// behavioural 8-bit ALU (sel 0 = add with carry, any other sel = xor, c_out 0).
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // NBYTES=2 instance
    logic        req_valid, req_ready, req_c_in;
    logic [15:0] req_a, req_b;
    logic [3:0]  req_sel;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic        alu_c_in, alu_c_out;
    logic [3:0]  alu_sel;
    logic        rsp_valid, rsp_ready, rsp_c_out, rsp_zero;
    logic [15:0] rsp_result;

    // NBYTES=1 instance
    logic        n1_req_valid, n1_req_ready, n1_req_c_in;
    logic [7:0]  n1_req_a, n1_req_b;
    logic [3:0]  n1_req_sel;
    logic [7:0]  n1_alu_a, n1_alu_b, n1_alu_out;
    logic        n1_alu_c_in, n1_alu_c_out;
    logic [3:0]  n1_alu_sel;
    logic        n1_rsp_valid, n1_rsp_ready, n1_rsp_c_out, n1_rsp_zero;
    logic [7:0]  n1_rsp_result;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_seq #(.NBYTES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_c_in(req_c_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_c_out(alu_c_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_c_out(rsp_c_out), .rsp_zero(rsp_zero)
    );

    alu_seq #(.NBYTES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(n1_req_valid), .req_ready(n1_req_ready),
        .req_a(n1_req_a), .req_b(n1_req_b), .req_sel(n1_req_sel), .req_c_in(n1_req_c_in),
        .alu_a(n1_alu_a), .alu_b(n1_alu_b), .alu_c_in(n1_alu_c_in), .alu_sel(n1_alu_sel),
        .alu_out(n1_alu_out), .alu_c_out(n1_alu_c_out),
        .rsp_valid(n1_rsp_valid), .rsp_ready(n1_rsp_ready),
        .rsp_result(n1_rsp_result), .rsp_c_out(n1_rsp_c_out), .rsp_zero(n1_rsp_zero)
    );

    // Behavioural ALU for the 2-byte instance.
    always_comb begin
        if (alu_sel == 4'd0) begin
            {alu_c_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in};
        end else begin
            alu_out   = alu_a ^ alu_b;
            alu_c_out = 1'b0;
        end
    end

    // Behavioural ALU for the 1-byte instance.
    always_comb begin
        if (n1_alu_sel == 4'd0) begin
            {n1_alu_c_out, n1_alu_out} = {1'b0, n1_alu_a} + {1'b0, n1_alu_b} + {8'd0, n1_alu_c_in};
        end else begin
            n1_alu_out   = n1_alu_a ^ n1_alu_b;
            n1_alu_c_out = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge (caller ensures the DUT is idle).
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [3:0] sel);
        req_a = a; req_b = b; req_c_in = c; req_sel = sel; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Count cycles until rsp_valid; -1 when the bound expires.
    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        if (!rsp_valid) cyc = -1;
    endtask

    task automatic finish_op();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = '0; req_c_in = 1'b0; rsp_ready = 1'b0;
        n1_req_valid = 1'b0; n1_req_a = '0; n1_req_b = '0; n1_req_sel = '0; n1_req_c_in = 1'b0;
        n1_rsp_ready = 1'b0;
        #3;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h want 0000", rsp_result); end
        n_cmp++; if (rsp_c_out !== 1'b0) begin n_fail++; $display("FAIL reset_c_out: got %b want 0", rsp_c_out); end
        n_cmp++; if (rsp_zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b want 1", rsp_zero); end
        n_cmp++; if ({alu_a, alu_b, alu_c_in, alu_sel} !== 21'd0) begin n_fail++; $display("FAIL reset_alu: got %h %h %b %h want all 0", alu_a, alu_b, alu_c_in, alu_sel); end
        n_cmp++; if ({n1_req_ready, n1_rsp_valid, n1_rsp_zero} !== 3'b101) begin n_fail++; $display("FAIL reset_n1: got %b want 101", {n1_req_ready, n1_rsp_valid, n1_rsp_zero}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_carry();
        issue(16'h00FF, 16'h0001, 1'b0, 4'd0);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL carry_exec_ready: got %b want 0", req_ready); end
        n_cmp++; if ({alu_a, alu_b, alu_c_in} !== {8'hFF, 8'h01, 1'b0}) begin n_fail++; $display("FAIL carry_byte0_in: got %h %h %b want ff 01 0", alu_a, alu_b, alu_c_in); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL carry_early_valid: got %b want 0", rsp_valid); end
        n_cmp++; if ({alu_a, alu_b, alu_c_in} !== {8'h00, 8'h00, 1'b1}) begin n_fail++; $display("FAIL carry_byte1_in: got %h %h %b want 00 00 1", alu_a, alu_b, alu_c_in); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL carry_latency: rsp_valid got %b want 1 two cycles after accept", rsp_valid); end
        n_cmp++; if (rsp_result !== 16'h0100) begin n_fail++; $display("FAIL carry_result: got %h want 0100", rsp_result); end
        n_cmp++; if ({rsp_c_out, rsp_zero} !== 2'b00) begin n_fail++; $display("FAIL carry_flags: got c=%b z=%b want c=0 z=0", rsp_c_out, rsp_zero); end
        n_cmp++; if ({alu_a, alu_b, alu_c_in, alu_sel} !== 21'd0) begin n_fail++; $display("FAIL carry_done_alu: got %h %h %b %h want all 0", alu_a, alu_b, alu_c_in, alu_sel); end
        finish_op();
        n_cmp++; if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL carry_back_idle: got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_wrap();
        int cyc;
        issue(16'hFFFF, 16'h0001, 1'b0, 4'd0);
        wait_rsp(cyc);
        n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL wrap1_latency: got %0d want 2", cyc); end
        n_cmp++; if ({rsp_result, rsp_c_out, rsp_zero} !== {16'h0000, 1'b1, 1'b1}) begin n_fail++; $display("FAIL wrap1: got %h c=%b z=%b want 0000 c=1 z=1", rsp_result, rsp_c_out, rsp_zero); end
        finish_op();
        issue(16'hFFFF, 16'hFFFF, 1'b1, 4'd0);
        wait_rsp(cyc);
        n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL wrap2_latency: got %0d want 2", cyc); end
        n_cmp++; if ({rsp_result, rsp_c_out, rsp_zero} !== {16'hFFFF, 1'b1, 1'b0}) begin n_fail++; $display("FAIL wrap2: got %h c=%b z=%b want ffff c=1 z=0", rsp_result, rsp_c_out, rsp_zero); end
        finish_op();
    endtask

    task automatic test_sel_passthru();
        int cyc;
        issue(16'h0F0F, 16'h00FF, 1'b1, 4'd3);
        n_cmp++; if ({alu_sel, alu_c_in} !== {4'd3, 1'b1}) begin n_fail++; $display("FAIL sel_drive: got sel=%h c=%b want 3 1", alu_sel, alu_c_in); end
        wait_rsp(cyc);
        n_cmp++; if ({rsp_result, rsp_c_out} !== {16'h0FF0, 1'b0}) begin n_fail++; $display("FAIL sel_result: got %h c=%b want 0ff0 c=0", rsp_result, rsp_c_out); end
        finish_op();
    endtask

    task automatic test_backpressure();
        int cyc;
        int bad;
        issue(16'hF000, 16'h1234, 1'b0, 4'd0);
        wait_rsp(cyc);
        n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL bp_latency: got %0d want 2", cyc); end
        // A request presented during DONE must be ignored.
        req_valid = 1'b1; req_a = 16'hAAAA; req_b = 16'h5555;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_result !== 16'h0234 || rsp_c_out !== 1'b1 ||
                req_ready !== 1'b0 || alu_a !== 8'h00) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got valid=%b res=%h c=%b ready=%b alu_a=%h want 1 0234 1 0 00",
                         i, rsp_valid, rsp_result, rsp_c_out, req_ready, alu_a);
            end
        end
        n_cmp++; if (bad != 0) n_fail++;
        req_valid = 1'b0;
        finish_op();
        n_cmp++; if ({req_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_release: got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int          gap;
        int          cyc;
        logic        got1;
        logic        acc;
        logic [15:0] res1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_start_ready: got %b want 1", req_ready); end
        rsp_ready = 1'b1;
        req_a = 16'h1234; req_b = 16'h1111; req_c_in = 1'b0; req_sel = 4'd0; req_valid = 1'b1;
        tick();
        req_a = 16'h0F0F; req_b = 16'h0101;
        gap = -1; got1 = 1'b0; res1 = '0;
        for (int k = 1; k <= 10; k++) begin
            acc = req_ready;
            if (rsp_valid) begin
                got1 = 1'b1;
                res1 = rsp_result;
            end
            tick();
            if (acc) begin
                gap = k;
                break;
            end
        end
        req_valid = 1'b0;
        n_cmp++; if (gap !== 4) begin n_fail++; $display("FAIL b2b_gap: got %0d want 4", gap); end
        n_cmp++; if ({got1, res1} !== {1'b1, 16'h2345}) begin n_fail++; $display("FAIL b2b_res1: got seen=%b %h want 1 2345", got1, res1); end
        wait_rsp(cyc);
        n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL b2b_latency2: got %0d want 2", cyc); end
        n_cmp++; if ({rsp_result, rsp_c_out} !== {16'h1010, 1'b0}) begin n_fail++; $display("FAIL b2b_res2: got %h c=%b want 1010 c=0", rsp_result, rsp_c_out); end
        tick();
        rsp_ready = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_end_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_reset_mid_op();
        int   cyc;
        logic seen;
        issue(16'h5555, 16'h1111, 1'b0, 4'd0);
        tick();
        n_cmp++; if ({alu_a, alu_b} !== {8'h55, 8'h11}) begin n_fail++; $display("FAIL rst_byte1_in: got %h %h want 55 11", alu_a, alu_b); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_async_hs: got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
        n_cmp++; if ({alu_a, alu_b, alu_c_in, alu_sel} !== 21'd0) begin n_fail++; $display("FAIL rst_async_alu: got %h %h %b %h want all 0", alu_a, alu_b, alu_c_in, alu_sel); end
        n_cmp++; if ({rsp_result, rsp_zero} !== {16'h0000, 1'b1}) begin n_fail++; $display("FAIL rst_async_result: got %h z=%b want 0000 z=1", rsp_result, rsp_zero); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_rsp: got response %b want 0", seen); end
        issue(16'h0001, 16'h0001, 1'b0, 4'd0);
        wait_rsp(cyc);
        n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL rst_next_latency: got %0d want 2", cyc); end
        n_cmp++; if ({rsp_result, rsp_c_out, rsp_zero} !== {16'h0002, 1'b0, 1'b0}) begin n_fail++; $display("FAIL rst_next_result: got %h c=%b z=%b want 0002 0 0", rsp_result, rsp_c_out, rsp_zero); end
        finish_op();
    endtask

    task automatic test_nbytes1();
        n_cmp++; if (n1_req_ready !== 1'b1) begin n_fail++; $display("FAIL n1_ready: got %b want 1", n1_req_ready); end
        n1_req_a = 8'hFF; n1_req_b = 8'h01; n1_req_c_in = 1'b0; n1_req_sel = 4'd0; n1_req_valid = 1'b1;
        tick();
        n1_req_valid = 1'b0;
        n_cmp++; if ({n1_rsp_valid, n1_alu_a, n1_alu_b} !== {1'b0, 8'hFF, 8'h01}) begin n_fail++; $display("FAIL n1_exec: got valid=%b %h %h want 0 ff 01", n1_rsp_valid, n1_alu_a, n1_alu_b); end
        tick();
        n_cmp++; if (n1_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL n1_latency: rsp_valid got %b want 1 one cycle after accept", n1_rsp_valid); end
        n_cmp++; if ({n1_rsp_result, n1_rsp_c_out, n1_rsp_zero} !== {8'h00, 1'b1, 1'b1}) begin n_fail++; $display("FAIL n1_result: got %h c=%b z=%b want 00 1 1", n1_rsp_result, n1_rsp_c_out, n1_rsp_zero); end
        n1_rsp_ready = 1'b1;
        tick();
        n1_rsp_ready = 1'b0;
        n_cmp++; if ({n1_req_ready, n1_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL n1_idle: got ready=%b valid=%b want 1 0", n1_req_ready, n1_rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_wrap();
        test_sel_passthru();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_nbytes1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
